// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RV32I subset (lw, sw, R-type, I-type ALU, beq).
// Sequences the shared ALU, memory port and register file; traps illegal opcodes and counts retirements.
module multicycle_controller #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             AdrSrc,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       ImmSrc,
   output logic             RegWrite,
   output logic             illegal,
   output logic             instr_retired,
   output logic [CNT_W-1:0] retired_count
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_TRAP
   } state_t;

   state_t           state_q, state_d;
   logic             illegal_q;
   logic             retired_q;
   logic [CNT_W-1:0] count_q;
   logic             retire;
   logic             pc_update, branch, ir_wr, mem_wr, reg_wr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_BEQ:       state_d = S_BEQ;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_FETCH;
      endcase
   end

   // Retirement is decided on the edge leaving a final state; TRAP entry never counts.
   assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BEQ) ||
                   ((state_q == S_MEMWRITE) && mem_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_q <= 1'b0;
         retired_q <= 1'b0;
         count_q   <= '0;
      end else begin
         illegal_q <= illegal_q | (state_d == S_TRAP);
         retired_q <= retire;
         count_q   <= count_q + {{(CNT_W-1){1'b0}}, retire};
      end
   end

   always_comb begin
      pc_update = 1'b0;
      branch    = 1'b0;
      ir_wr     = 1'b0;
      mem_wr    = 1'b0;
      reg_wr    = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      case (state_q)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            ir_wr     = mem_ready;
            pc_update = mem_ready;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            reg_wr    = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            mem_wr = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
         end
         S_EXECUTEI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
         end
         S_ALUWB:    reg_wr = 1'b1;
         S_BEQ: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b01;
            branch  = 1'b1;
         end
         default: ;
      endcase
   end

   // Write strobes are masked combinationally so they stay low for the whole reset pulse.
   assign PCWrite  = rst_n & (pc_update | (branch & zero));
   assign IRWrite  = rst_n & ir_wr;
   assign MemWrite = rst_n & mem_wr;
   assign RegWrite = rst_n & reg_wr;

   always_comb begin
      case (opcode)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         default: ImmSrc = 2'b00;
      endcase
   end

   assign illegal       = illegal_q;
   assign instr_retired = retired_q;
   assign retired_count = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle control decode checks plus a retire scoreboard.
module tb_multicycle_controller;

   localparam int CNT_W = 4;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3, ST_MEMWB = 4,
                  ST_MEMWRITE = 5, ST_EXR = 6, ST_EXI = 7, ST_ALUWB = 8, ST_BEQ = 9, ST_TRAP = 10;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [6:0]       opcode;
   logic             zero;
   logic             mem_ready;
   logic             PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal, instr_retired;
   logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
   logic [CNT_W-1:0] retired_count;
   logic [16:0]      ctrl_obs;

   int n_chk  = 0;
   int n_pass = 0;
   int exp_cnt = 0;
   int exp_q[$];

   multicycle_controller #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal(illegal),
      .instr_retired(instr_retired), .retired_count(retired_count)
   );

   always #5 clk = ~clk;

   assign ctrl_obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                      ALUOp, ImmSrc, RegWrite, illegal};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Reference decode: {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,RegWrite,illegal}
   function automatic logic [16:0] exp_ctrl(input int st, input logic [6:0] op, input logic mr,
                                            input logic z, input logic rst_low);
      logic pcw, adr, mw, irw, rw, ill;
      logic [1:0] rs, sa, sb, aop, imm;
      pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
      rs = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00;
      imm = (op == OP_SW) ? 2'b01 : (op == OP_BEQ) ? 2'b10 : 2'b00;
      case (st)
         ST_FETCH:    begin sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
         ST_DECODE:   begin sa = 2'b01; sb = 2'b01; end
         ST_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
         ST_MEMREAD:  adr = 1;
         ST_MEMWB:    begin rs = 2'b01; rw = 1; end
         ST_MEMWRITE: begin adr = 1; mw = 1; end
         ST_EXR:      begin sa = 2'b10; sb = 2'b00; aop = 2'b10; end
         ST_EXI:      begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
         ST_ALUWB:    rw = 1;
         ST_BEQ:      begin sa = 2'b10; aop = 2'b01; pcw = z; end
         ST_TRAP:     ill = 1;
         default: ;
      endcase
      if (rst_low) begin pcw = 0; irw = 0; mw = 0; rw = 0; end
      return {pcw, adr, mw, irw, rs, sa, sb, aop, imm, rw, ill};
   endfunction

   // Scoreboard consumer: each retire pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      int e;
      if (instr_retired === 1'b1) begin
         if (exp_q.size() == 0) chk("spurious_retire", 32'd1, 32'd0);
         else begin
            e = exp_q.pop_front();
            chk("retire_count", 32'(retired_count), 32'(e));
         end
      end
   end

   // Entered just after a rising edge with the DUT in FETCH; returns just after the edge that retires.
   task automatic run_instr(input logic [6:0] op, input logic z, input int fw, input int mw);
      int   st[$];
      logic mr[$];
      for (int i = 0; i <= fw; i++) begin st.push_back(ST_FETCH); mr.push_back(i == fw); end
      st.push_back(ST_DECODE); mr.push_back(1'($urandom));
      case (op)
         OP_LW: begin
            st.push_back(ST_MEMADR); mr.push_back(1'($urandom));
            for (int i = 0; i <= mw; i++) begin st.push_back(ST_MEMREAD); mr.push_back(i == mw); end
            st.push_back(ST_MEMWB); mr.push_back(1'($urandom));
         end
         OP_SW: begin
            st.push_back(ST_MEMADR); mr.push_back(1'($urandom));
            for (int i = 0; i <= mw; i++) begin st.push_back(ST_MEMWRITE); mr.push_back(i == mw); end
         end
         OP_R:    begin st.push_back(ST_EXR); mr.push_back(1'($urandom));
                        st.push_back(ST_ALUWB); mr.push_back(1'($urandom)); end
         OP_I:    begin st.push_back(ST_EXI); mr.push_back(1'($urandom));
                        st.push_back(ST_ALUWB); mr.push_back(1'($urandom)); end
         default: begin st.push_back(ST_BEQ); mr.push_back(1'($urandom)); end
      endcase
      opcode = op;
      for (int i = 0; i < st.size(); i++) begin
         mem_ready = mr[i];
         zero      = (st[i] == ST_BEQ) ? z : 1'($urandom);
         @(negedge clk);
         chk($sformatf("ctrl op=%b cyc=%0d", op, i), 32'(ctrl_obs),
             32'(exp_ctrl(st[i], op, mr[i], zero, 1'b0)));
         if (i == st.size() - 1) begin
            exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
            exp_q.push_back(exp_cnt);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic apply_reset_now(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, "_ctrl"}, 32'(ctrl_obs), 32'(exp_ctrl(ST_FETCH, opcode, mem_ready, zero, 1'b1)));
      chk({tag, "_count"}, 32'(retired_count), 32'd0);
      chk({tag, "_retired"}, 32'(instr_retired), 32'd0);
      exp_cnt = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic trap_test();
      int seq[4] = '{ST_FETCH, ST_DECODE, ST_TRAP, ST_TRAP};
      opcode = OP_JAL;
      for (int i = 0; i < 7; i++) begin
         mem_ready = (i == 0) ? 1'b1 : 1'($urandom);
         zero      = 1'($urandom);
         @(negedge clk);
         chk($sformatf("trap cyc=%0d", i), 32'(ctrl_obs),
             32'(exp_ctrl(seq[(i < 3) ? i : 3], OP_JAL, mem_ready, zero, 1'b0)));
         @(posedge clk); #1;
      end
      chk("trap_count_held", 32'(retired_count), 32'(exp_cnt));
      mem_ready = 1'b1;
      apply_reset_now("trap_reset");
   endtask

   task automatic abort_test();
      int seq[3] = '{ST_FETCH, ST_DECODE, ST_EXI};
      opcode = OP_I;
      for (int i = 0; i < 3; i++) begin
         mem_ready = 1'b1;
         zero      = 1'($urandom);
         @(negedge clk);
         chk($sformatf("abort cyc=%0d", i), 32'(ctrl_obs),
             32'(exp_ctrl(seq[i], OP_I, 1'b1, zero, 1'b0)));
         if (i < 2) begin @(posedge clk); #1; end
      end
      #2;
      apply_reset_now("abort_reset");
   endtask

   initial begin
      rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = 7'd0;
      #3;
      chk("reset_ctrl", 32'(ctrl_obs), 32'(exp_ctrl(ST_FETCH, 7'd0, 1'b1, 1'b0, 1'b1)));
      chk("reset_count", 32'(retired_count), 32'd0);
      chk("reset_retired", 32'(instr_retired), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_instr(OP_R,   1'b0, 0, 0);
      run_instr(OP_LW,  1'b0, 0, 2);
      run_instr(OP_SW,  1'b0, 0, 3);
      run_instr(OP_BEQ, 1'b1, 0, 0);
      run_instr(OP_BEQ, 1'b0, 0, 0);
      run_instr(OP_I,   1'b0, 2, 0);
      run_instr(OP_LW,  1'b0, 1, 1);
      run_instr(OP_SW,  1'b0, 0, 0);

      trap_test();

      for (int k = 0; k < 17; k++) run_instr(OP_I, 1'b0, 0, 0);
      chk("wrap_count", 32'(retired_count), 32'd1);

      abort_test();
      run_instr(OP_R, 1'b0, 0, 0);

      mem_ready = 1'b0;
      @(negedge clk); #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
